synth_cfg_arbiter: RTL and testbench

Shares the synth's byte-serial configuration write port between several on-chip requesters, for example a host SPI bridge and an envelope/sweep sequencer. Each requester submits 16-bit word writes with byte enables. The block selects one request at a time by round-robin and emits each enabled byte as a strobe transaction on the synth's config pins (data on `uio_in`, address/byte-select/strobe on `ui_in`). Strobe high and low phases are long enough to survive the synth's 2-flop strobe synchroniser and rising-edge detector.

---
 rtl/synth_cfg_pkg.sv | 26 ++
 rtl/synth_cfg_arbiter_rr.sv | 40 ++++
 rtl/synth_cfg_arbiter.sv | 137 +++++++++++++
 tb/tb_synth_cfg_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_cfg_pkg.sv
// Shared types, sizes and pin map for the synth config-port arbiter.
package synth_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE_HI,
    STROBE_LO
  } state_t;

  localparam int CFG_ADDR_BITS = 3;
  localparam int CFG_WORDS     = 8;

  localparam int PIN_BYTE    = 0;
  localparam int PIN_ADDR_LO = 1;
  localparam int PIN_ADDR_HI = 3;
  localparam int PIN_STROBE  = 7;

  function automatic logic [7:0] byte_of(
    input logic [15:0] w,
    input logic        hi
  );
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/synth_cfg_arbiter_rr.sv
// Round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W:0]     off;
  logic [IDX_W:0]     sum;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = (IDX_W + 1)'(k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IDX_W + 1)'(NUM_REQ))
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    idx   = sum[IDX_W-1:0];
    grant = (|req) ? (NUM_REQ'(1) << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (accept)
      ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/synth_cfg_arbiter.sv
// Serialises requesters' 16-bit word writes into byte strobes
// on the synth's config pins, one word at a time.
module synth_cfg_arbiter
  import synth_cfg_pkg::*;
#(
  parameter  int NUM_REQ      = 2,
  parameter  int SETUP_CYCLES = 1,
  parameter  int HI_CYCLES    = 4,
  parameter  int LO_CYCLES    = 4,
  parameter  int CNT_BITS     = 4,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [3*NUM_REQ-1:0]     req_addr,
  input  logic [2*NUM_REQ-1:0]     req_be,
  input  logic [16*NUM_REQ-1:0]    req_data,
  output logic [7:0]               cfg_data,
  output logic [CFG_ADDR_BITS-1:0] cfg_addr,
  output logic                     cfg_byte,
  output logic                     cfg_strobe,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id
);

  localparam logic [CNT_BITS-1:0] SETUP_N = CNT_BITS'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] HI_N    = CNT_BITS'(HI_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] LO_N    = CNT_BITS'(LO_CYCLES - 1);

  state_t                   state;
  logic [CNT_BITS-1:0]      cnt;
  logic [7:0]               hi_byte;
  logic                     hi_pending;
  logic                     accept;
  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         idx;
  logic [CFG_ADDR_BITS-1:0] sel_addr;
  logic [1:0]               sel_be;
  logic [15:0]              sel_data;

  assign accept    = (state == IDLE) && (|req_valid) && !reset;
  assign req_ready = accept ? grant : '0;
  assign busy      = (state != IDLE);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .accept(accept),
    .grant (grant),
    .idx   (idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_be   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[3*i +: 3];
        sel_be   = req_be[2*i +: 2];
        sel_data = req_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_byte    <= '0;
      hi_pending <= 1'b0;
      cfg_data   <= '0;
      cfg_addr   <= '0;
      cfg_byte   <= 1'b0;
      cfg_strobe <= 1'b0;
      grant_id   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant_id   <= idx;
            hi_byte    <= sel_data[15:8];
            hi_pending <= &sel_be;
            // An all-zero enable is consumed here without a strobe.
            if (|sel_be) begin
              state    <= SETUP;
              cnt      <= SETUP_N;
              cfg_addr <= sel_addr;
              cfg_byte <= ~sel_be[0];
              cfg_data <= byte_of(sel_data, ~sel_be[0]);
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state      <= STROBE_HI;
            cnt        <= HI_N;
            cfg_strobe <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE_HI: begin
          if (cnt == '0) begin
            state      <= STROBE_LO;
            cnt        <= LO_N;
            cfg_strobe <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE_LO: begin
          if (cnt == '0) begin
            if (hi_pending) begin
              state      <= SETUP;
              cnt        <= SETUP_N;
              hi_pending <= 1'b0;
              cfg_byte   <= 1'b1;
              cfg_data   <= hi_byte;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_cfg_arbiter.sv
// Bench for synth_cfg_arbiter: default-timing and minimum-timing instances,
// a transaction-level output model and a synth-side strobe capture model.
module tb_synth_cfg_arbiter;
  import synth_cfg_pkg::*;

  localparam int NI = 2;

  int sc [NI] = '{1, 4 - 2};
  int hc [NI] = '{4, 3};
  int lc [NI] = '{4, 3};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic clr   = 1'b1;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]  valid  [NI];
  logic [5:0]  addr_v [NI];
  logic [3:0]  be_v   [NI];
  logic [31:0] data_v [NI];
  logic [1:0]  ready  [NI];
  logic [7:0]  cd     [NI];
  logic [2:0]  ca     [NI];
  logic        cb     [NI];
  logic        cs     [NI];
  logic        bz     [NI];
  logic [0:0]  gid    [NI];

  synth_cfg_arbiter #(
    .NUM_REQ(2)
  ) u_def (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid[0]),
    .req_ready (ready[0]),
    .req_addr  (addr_v[0]),
    .req_be    (be_v[0]),
    .req_data  (data_v[0]),
    .cfg_data  (cd[0]),
    .cfg_addr  (ca[0]),
    .cfg_byte  (cb[0]),
    .cfg_strobe(cs[0]),
    .busy      (bz[0]),
    .grant_id  (gid[0])
  );

  synth_cfg_arbiter #(
    .NUM_REQ     (2),
    .SETUP_CYCLES(2),
    .HI_CYCLES   (3),
    .LO_CYCLES   (3)
  ) u_min (
    .clk       (clk),
    .reset     (reset),
    .req_valid (valid[1]),
    .req_ready (ready[1]),
    .req_addr  (addr_v[1]),
    .req_be    (be_v[1]),
    .req_data  (data_v[1]),
    .cfg_data  (cd[1]),
    .cfg_addr  (ca[1]),
    .cfg_byte  (cb[1]),
    .cfg_strobe(cs[1]),
    .busy      (bz[1]),
    .grant_id  (gid[1])
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Synth side: pins as the synth sees them, 2-flop sync + edge detect.
  logic [7:0]  ui    [NI];
  logic [2:0]  sync  [NI];
  logic [15:0] mem   [NI][8];
  int          edges [NI];

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      ui[i] = '0;
      ui[i][PIN_STROBE] = cs[i];
      ui[i][PIN_ADDR_HI:PIN_ADDR_LO] = ca[i];
      ui[i][PIN_BYTE] = cb[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      sync[i] <= {sync[i][1:0], ui[i][PIN_STROBE]};
      if (clr) begin
        edges[i] <= 0;
        for (int w = 0; w < CFG_WORDS; w++) mem[i][w] <= '0;
      end else if (sync[i][1] && !sync[i][2]) begin
        edges[i] <= edges[i] + 1;
        if (ui[i][PIN_BYTE])
          mem[i][ui[i][PIN_ADDR_HI:PIN_ADDR_LO]][15:8] <= cd[i];
        else
          mem[i][ui[i][PIN_ADDR_HI:PIN_ADDR_LO]][7:0] <= cd[i];
      end
    end
  end

  // Transaction model: each accepted word becomes a list of bytes, each
  // byte a window of SETUP+HI+LO cycles starting the cycle after accept.
  int         cyc = 0;
  int         m_end [NI] = '{-1, -1};
  int         m_acc [NI];
  int         m_n   [NI];
  int         m_rr  [NI];
  logic [7:0] m_d   [NI][2];
  logic       m_b   [NI][2];
  logic [2:0] m_a   [NI];
  logic [7:0] o_d   [NI];
  logic [2:0] o_a   [NI];
  logic       o_b   [NI];
  logic       m_gid [NI];
  logic [15:0] e_mem [NI][8];
  int         e_edges [NI];

  function automatic int pick(input logic [1:0] v, input int ptr);
    for (int k = 0; k < 2; k++) begin
      int j;
      j = (ptr + k) % 2;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  int          plen, o, ph, k, w;
  logic        idle, strb;
  logic [1:0]  rdy, mbe;
  logic [2:0]  ma;
  logic [15:0] md;
  logic [16:0] exp_v, act_v;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      plen = sc[i] + hc[i] + lc[i];
      idle = (cyc > m_end[i]);
      w = -1;
      if (!idle) begin
        o    = cyc - m_acc[i] - 1;
        k    = o / plen;
        ph   = o % plen;
        strb = (ph >= sc[i]) && (ph < sc[i] + hc[i]);
        exp_v = {2'b00, m_gid[i], 1'b1, strb, m_b[i][k], m_a[i], m_d[i][k]};
        if (ph == sc[i]) begin
          if (m_b[i][k]) e_mem[i][m_a[i]][15:8] = m_d[i][k];
          else           e_mem[i][m_a[i]][7:0]  = m_d[i][k];
          e_edges[i]++;
        end
      end else begin
        w   = reset ? -1 : pick(valid[i], m_rr[i]);
        rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        exp_v = {rdy, m_gid[i], 1'b0, 1'b0, o_b[i], o_a[i], o_d[i]};
      end
      act_v = {ready[i], gid[i], bz[i], cs[i], cb[i], ca[i], cd[i]};
      if (chk_on)
        chk($sformatf("outs%0d@%0d", i, cyc), 32'(act_v), 32'(exp_v));
      if (reset) begin
        m_end[i] = -1;
        m_rr[i]  = 0;
        m_gid[i] = 1'b0;
        o_d[i]   = '0;
        o_a[i]   = '0;
        o_b[i]   = 1'b0;
      end else if (w >= 0) begin
        m_gid[i] = w[0];
        m_rr[i]  = (w + 1) % 2;
        ma  = addr_v[i][3*w +: 3];
        mbe = be_v[i][2*w +: 2];
        md  = data_v[i][16*w +: 16];
        m_n[i] = 0;
        if (mbe[0]) begin
          m_d[i][m_n[i]] = md[7:0];
          m_b[i][m_n[i]] = 1'b0;
          m_n[i]++;
        end
        if (mbe[1]) begin
          m_d[i][m_n[i]] = md[15:8];
          m_b[i][m_n[i]] = 1'b1;
          m_n[i]++;
        end
        if (m_n[i] > 0) begin
          m_a[i]   = ma;
          m_acc[i] = cyc;
          m_end[i] = cyc + m_n[i] * plen;
          o_d[i]   = m_d[i][m_n[i]-1];
          o_b[i]   = m_b[i][m_n[i]-1];
          o_a[i]   = ma;
        end
      end
    end
    if (clr) begin
      for (int i = 0; i < NI; i++) begin
        e_edges[i] = 0;
        for (int a = 0; a < CFG_WORDS; a++) e_mem[i][a] = '0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          nb, np, gcyc_prev;
  logic        prev;
  logic [8:0]  pl [4];
  int          gq [$];
  int          gc [$];
  logic [1:0]  rs [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      valid[i]  = '0;
      addr_v[i] = '0;
      be_v[i]   = '0;
      data_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    clr    = 1'b0;
    chk_on = 1'b1;

    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset outs%0d", i),
          32'({ready[i], gid[i], bz[i], cs[i], cb[i], ca[i], cd[i]}), 32'h0);

    // Single low byte from requester 0.
    step();
    valid[0] = 2'b01; addr_v[0] = 6'd2; be_v[0] = 4'b0001;
    data_v[0] = 32'h0000_12AB;
    @(negedge clk);
    chk("t1 ready", 32'(ready[0]), 32'h1);
    step();
    valid[0] = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("t1 strobe T+%0d", c), 32'(cs[0]), 32'(c >= 2 && c <= 5));
      chk($sformatf("t1 busy T+%0d", c), 32'(bz[0]), 32'(c <= 9));
      if (c == 3)
        chk("t1 pins", 32'({cd[0], ca[0], cb[0]}), 32'({8'hAB, 3'd2, 1'b0}));
    end
    chk("t1 synth cfg[2] low", 32'(mem[0][2][7:0]), 32'hAB);

    // Full word from requester 1.
    step();
    valid[0] = 2'b10; addr_v[0] = {3'd5, 3'd0}; be_v[0] = 4'b1100;
    data_v[0] = {16'hBEEF, 16'h0};
    @(negedge clk);
    chk("t2 ready", 32'(ready[0]), 32'h2);
    step();
    valid[0] = '0;
    nb = 0; np = 0; prev = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      nb += int'(bz[0]);
      if (cs[0] && !prev && np < 4) begin
        pl[np] = {cd[0], cb[0]};
        np++;
      end
      prev = cs[0];
    end
    chk("t2 busy cycles", 32'(nb), 32'd18);
    chk("t2 pulses", 32'(np), 32'd2);
    chk("t2 first byte", 32'(pl[0]), 32'({8'hEF, 1'b0}));
    chk("t2 second byte", 32'(pl[1]), 32'({8'hBE, 1'b1}));
    chk("t2 synth cfg[5]", 32'(mem[0][5]), 32'hBEEF);

    // Zero byte enables: accepted, no strobe, accept again next cycle.
    step();
    valid[0] = 2'b01; be_v[0] = 4'b0000;
    @(negedge clk);
    chk("t3 ready0", 32'(ready[0]), 32'h1);
    step();
    valid[0] = 2'b10;
    @(negedge clk);
    chk("t3 busy/strobe", 32'({bz[0], cs[0]}), 32'h0);
    chk("t3 ready1", 32'(ready[0]), 32'h2);
    step();
    valid[0] = '0;
    @(negedge clk);
    chk("t3 grant_id", 32'(gid[0]), 32'h1);
    chk("t3 idle", 32'(bz[0]), 32'h0);

    // Round robin with both requesters always valid.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    valid[0] = 2'b11; addr_v[0] = {3'd3, 3'd1}; be_v[0] = 4'b1111;
    data_v[0] = {16'h5555, 16'hAAAA};
    for (int c = 0; c < 78; c++) begin
      @(negedge clk);
      if (ready[0] != 2'b00) begin
        gq.push_back(ready[0] == 2'b10 ? 1 : 0);
        gc.push_back(c);
      end
    end
    step();
    valid[0] = '0;
    chk("t4 grant count", 32'(gq.size() >= 4), 32'h1);
    if (gq.size() >= 4) begin
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("t4 grant %0d", g), 32'(gq[g]), 32'(g % 2));
        if (g > 0)
          chk($sformatf("t4 gap %0d", g), 32'(gc[g] - gc[g-1]), 32'd19);
      end
    end
    repeat (20) step();

    // Reset in the middle of a two-byte word.
    valid[0] = 2'b01; addr_v[0] = {3'd0, 3'd4}; be_v[0] = 4'b0011;
    data_v[0] = 32'h0000_1234;
    @(negedge clk);
    chk("t5 ready", 32'(ready[0]), 32'h1);
    step();
    valid[0] = '0;
    step();
    @(negedge clk);
    chk("t5 strobe up", 32'(cs[0]), 32'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    valid[0] = 2'b11; addr_v[0] = {3'd6, 3'd7}; be_v[0] = 4'b0101;
    data_v[0] = 32'h0077_00C3;
    @(negedge clk);
    chk("t5 outs after reset",
        32'({gid[0], bz[0], cs[0], cb[0], ca[0], cd[0]}), 32'h0);
    chk("t5 rr restart", 32'(ready[0]), 32'h1);
    step();
    valid[0] = '0;
    repeat (14) step();
    @(negedge clk);
    chk("t5 served", 32'(mem[0][7][7:0]), 32'hC3);
    chk("t5 idle", 32'(bz[0]), 32'h0);

    step();
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Randomised traffic on both timing variants.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) rs[i] = ready[i];
      step();
      for (int i = 0; i < NI; i++) begin
        for (int r = 0; r < 2; r++) begin
          if ((valid[i][r] && rs[i][r] && $urandom_range(0, 1) == 1) ||
              (!valid[i][r] && $urandom_range(0, 3) == 0)) begin
            valid[i][r] = 1'b1;
            addr_v[i][3*r +: 3]  = 3'($urandom_range(0, 7));
            be_v[i][2*r +: 2]    = 2'($urandom_range(0, 3));
            data_v[i][16*r +: 16] = 16'($urandom);
          end else if (valid[i][r] && rs[i][r]) begin
            valid[i][r] = 1'b0;
          end else if (valid[i][r] && $urandom_range(0, 7) == 0) begin
            data_v[i][16*r +: 16] = 16'($urandom);
          end
        end
      end
    end
    for (int i = 0; i < NI; i++) valid[i] = '0;
    repeat (60) step();

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("edges%0d", i), 32'(edges[i]), 32'(e_edges[i]));
      for (int a = 0; a < CFG_WORDS; a++)
        chk($sformatf("cfg%0d[%0d]", i, a), 32'(mem[i][a]), 32'(e_mem[i][a]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
